// File: rtl/pattern_sequencer.sv
// Step-table choreography controller for the LED pattern generator: plays
// (pattern, speed, duration) entries in order, timed by an external tick strobe.
module pattern_sequencer #(
  parameter int NUM_STEPS = 8,
  parameter int ADDR_W    = 3,
  parameter int DUR_W     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DUR_W+3:0]  cfg_data,
  input  logic [ADDR_W-1:0] cfg_last,
  input  logic              loop_en,
  input  logic              start,
  input  logic              stop,
  input  logic              hold,
  input  logic              skip,
  output logic [2:0]        pat_sel,
  output logic              speed_sel,
  output logic              pause,
  output logic              busy,
  output logic [ADDR_W-1:0] step_idx,
  output logic              seq_done
);

  localparam int EW = DUR_W + 4;
  localparam logic [EW-1:0] RST_ENTRY = {{DUR_W{1'b0}}, 1'b0, 3'b111};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_HOLD = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [EW-1:0]     tbl_q [NUM_STEPS];
  logic [EW-1:0]     tbl_d [NUM_STEPS];
  logic [DUR_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        pat_sel_q, pat_sel_d;
  logic              speed_sel_q, speed_sel_d;
  logic              pause_q, pause_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] step_idx_q, step_idx_d;
  logic              seq_done_q, seq_done_d;

  logic [EW-1:0]     ld_entry;
  logic [2:0]        ld_pat;
  logic              ld_spd;
  logic [DUR_W-1:0]  ld_dur;
  logic [ADDR_W-1:0] last_eff;
  logic              at_last;
  logic              advance;

  // Out-of-range writes are dropped so a short table can never alias.
  always_comb begin
    for (int i = 0; i < NUM_STEPS; i++) begin
      tbl_d[i] = tbl_q[i];
    end
    if (cfg_we && (32'(cfg_addr) < NUM_STEPS)) begin
      tbl_d[cfg_addr] = cfg_data;
    end
  end

  assign ld_entry = tbl_q[step_idx_q];
  assign ld_pat   = ld_entry[2:0];
  assign ld_spd   = ld_entry[3];
  assign ld_dur   = ld_entry[EW-1:4];

  assign last_eff = (32'(cfg_last) > NUM_STEPS - 1) ? ADDR_W'(NUM_STEPS - 1) : cfg_last;
  // A live lowering of cfg_last below the current step also ends the pass.
  assign at_last  = (step_idx_q >= last_eff);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pat_sel_d   = pat_sel_q;
    speed_sel_d = speed_sel_q;
    pause_d     = pause_q;
    step_idx_d  = step_idx_q;
    seq_done_d  = 1'b0;
    advance     = 1'b0;

    case (state_q)
      S_IDLE: begin
        pause_d = 1'b1;
        if (start) begin
          step_idx_d = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        pat_sel_d   = ld_pat;
        speed_sel_d = ld_spd;
        pause_d     = 1'b0;
        cnt_d       = (ld_dur == '0) ? DUR_W'(1) : ld_dur;
        state_d     = S_RUN;
      end
      S_RUN: begin
        if (skip) begin
          advance = 1'b1;
        end else if (hold) begin
          state_d = S_HOLD;
          pause_d = 1'b1;
        end else if (tick) begin
          if (cnt_q <= DUR_W'(1)) begin
            advance = 1'b1;
          end else begin
            cnt_d = cnt_q - DUR_W'(1);
          end
        end
      end
      S_HOLD: begin
        pause_d = 1'b1;
        if (!hold) begin
          state_d = S_RUN;
          pause_d = 1'b0;
        end
      end
      S_DONE: begin
        pause_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        pause_d = 1'b1;
      end
    endcase

    if (advance) begin
      if (!at_last) begin
        step_idx_d = step_idx_q + ADDR_W'(1);
        state_d    = S_LOAD;
      end else if (loop_en) begin
        step_idx_d = '0;
        state_d    = S_LOAD;
      end else begin
        state_d    = S_DONE;
        seq_done_d = 1'b1;
        pause_d    = 1'b1;
      end
    end

    // Abort outranks every other request and never reports completion.
    if (stop && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      pause_d    = 1'b1;
      step_idx_d = '0;
      seq_done_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pat_sel_q   <= 3'b111;
      speed_sel_q <= 1'b0;
      pause_q     <= 1'b1;
      busy_q      <= 1'b0;
      step_idx_q  <= '0;
      seq_done_q  <= 1'b0;
      for (int i = 0; i < NUM_STEPS; i++) begin
        tbl_q[i] <= RST_ENTRY;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pat_sel_q   <= pat_sel_d;
      speed_sel_q <= speed_sel_d;
      pause_q     <= pause_d;
      busy_q      <= busy_d;
      step_idx_q  <= step_idx_d;
      seq_done_q  <= seq_done_d;
      for (int i = 0; i < NUM_STEPS; i++) begin
        tbl_q[i] <= tbl_d[i];
      end
    end
  end

  assign pat_sel   = pat_sel_q;
  assign speed_sel = speed_sel_q;
  assign pause     = pause_q;
  assign busy      = busy_q;
  assign step_idx  = step_idx_q;
  assign seq_done  = seq_done_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: a step-level reference model predicts every change of
// the output bundle (plus the ticks seen since the previous change); a monitor compares.
module tb_pattern_sequencer;

  localparam int NS = 6;
  localparam int AW = 3;
  localparam int DW = 6;
  localparam int EW = DW + 4;
  localparam int SW = 10;
  localparam int RW = SW + 8;
  localparam logic [SW-1:0] RST_SNAP = {1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 3'b000};

  logic          clk, rst, tick, cfg_we, loop_en, start, stop, hold, skip;
  logic [AW-1:0] cfg_addr, cfg_last, step_idx;
  logic [EW-1:0] cfg_data;
  logic [2:0]    pat_sel;
  logic          speed_sel, pause, busy, seq_done;

  int n_checks = 0;
  int n_fail   = 0;

  pattern_sequencer #(.NUM_STEPS(NS), .ADDR_W(AW), .DUR_W(DW)) dut (
    .clk(clk), .rst(rst), .tick(tick), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_last(cfg_last), .loop_en(loop_en), .start(start),
    .stop(stop), .hold(hold), .skip(skip), .pat_sel(pat_sel), .speed_sel(speed_sel),
    .pause(pause), .busy(busy), .step_idx(step_idx), .seq_done(seq_done)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [2:0]    m_tpat [NS];
  logic          m_tspd [NS];
  int            m_tdur [NS];
  int            m_last, m_idx, m_rem;
  bit            m_loop, m_play, m_hold;
  logic [2:0]    m_pat;
  logic          m_spd, m_pause, m_busy, m_done;
  logic [7:0]    m_ticks;
  logic [SW-1:0] m_prev;
  logic [RW-1:0] exp_q[$];

  function automatic logic [SW-1:0] m_snap();
    return {m_busy, m_pause, m_done, m_pat, m_spd, AW'(m_idx)};
  endfunction

  task automatic m_emit();
    logic [SW-1:0] s;
    s = m_snap();
    if (s != m_prev) begin
      exp_q.push_back({m_ticks, s});
      m_ticks = '0;
      m_prev  = s;
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NS; i++) begin
      m_tpat[i] = 3'b111; m_tspd[i] = 1'b0; m_tdur[i] = 0;
    end
    m_play = 0; m_hold = 0; m_idx = 0; m_rem = 0;
    m_pat = 3'b111; m_spd = 1'b0; m_pause = 1'b1; m_busy = 1'b0; m_done = 1'b0;
    m_emit();
  endtask

  task automatic m_load();
    m_pat   = m_tpat[m_idx];
    m_spd   = m_tspd[m_idx];
    m_rem   = (m_tdur[m_idx] == 0) ? 1 : m_tdur[m_idx];
    m_pause = 1'b0;
    m_emit();
  endtask

  task automatic m_advance();
    int le;
    le = (m_last > NS - 1) ? NS - 1 : m_last;
    if (m_idx < le) begin
      m_idx++; m_emit(); m_load();
    end else if (m_loop) begin
      m_idx = 0; m_emit(); m_load();
    end else begin
      m_done = 1'b1; m_pause = 1'b1; m_emit();
      m_done = 1'b0; m_busy = 1'b0; m_play = 0; m_emit();
    end
  endtask

  task automatic m_start();
    if (!m_play) begin
      m_play = 1; m_busy = 1'b1; m_idx = 0; m_emit(); m_load();
    end
  endtask

  task automatic m_tick();
    m_ticks++;
    if (m_play && !m_hold) begin
      m_rem--;
      if (m_rem == 0) m_advance();
    end
  endtask

  task automatic m_skip();
    if (m_play && !m_hold) m_advance();
  endtask

  task automatic m_stop();
    if (m_play) begin
      m_play = 0; m_hold = 0; m_idx = 0; m_pause = 1'b1; m_busy = 1'b0; m_emit();
    end
  endtask

  task automatic m_write(input int addr, input logic [EW-1:0] d);
    if (addr < NS) begin
      m_tpat[addr] = d[2:0]; m_tspd[addr] = d[3]; m_tdur[addr] = int'(d[EW-1:4]);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit            mon_en = 0;
  logic [SW-1:0] mon_prev = RST_SNAP;
  logic [7:0]    mon_ticks = '0;

  always @(negedge clk) begin
    logic [SW-1:0] cur;
    logic [RW-1:0] e;
    if (mon_en) begin
      cur = {busy, pause, seq_done, pat_sel, speed_sel, step_idx};
      if (cur !== mon_prev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_unexpected: got %h, expected nothing", {mon_ticks, cur});
        end else begin
          e = exp_q.pop_front();
          if ({mon_ticks, cur} !== e) begin
            n_fail++;
            $display("FAIL scoreboard_event: got %h, expected %h (ticks|busy|pause|done|pat|spd|idx)",
                     {mon_ticks, cur}, e);
          end
        end
        mon_prev  = cur;
        mon_ticks = '0;
      end
      if (tick) mon_ticks++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step_clk();
    @(posedge clk); #1;
  endtask

  task automatic gap();
    repeat (4) step_clk();
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) step_clk();
    check(name, exp_q.size(), 0);
  endtask

  task automatic drv_tick();
    tick = 1'b1; m_tick(); step_clk(); tick = 1'b0; gap();
  endtask

  task automatic drv_start();
    start = 1'b1; m_start(); step_clk(); start = 1'b0; gap();
  endtask

  task automatic drv_skip();
    skip = 1'b1; m_skip(); step_clk(); skip = 1'b0; gap();
  endtask

  task automatic drv_stop(input bit with_skip);
    stop = 1'b1; skip = with_skip; m_stop(); step_clk(); stop = 1'b0; skip = 1'b0; gap();
  endtask

  task automatic drv_hold_on(input bit with_tick);
    hold = 1'b1; tick = with_tick;
    if (with_tick) m_ticks++;
    if (m_play) begin m_hold = 1; m_pause = 1'b1; m_emit(); end
    step_clk(); tick = 1'b0; gap();
  endtask

  task automatic drv_hold_off();
    hold = 1'b0;
    if (m_hold) begin m_hold = 0; m_pause = 1'b0; m_emit(); end
    step_clk(); gap();
  endtask

  task automatic drv_write(input int addr, input logic [EW-1:0] d);
    cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_data = d; m_write(addr, d);
    step_clk(); cfg_we = 1'b0;
  endtask

  task automatic set_cfg(input int last, input bit lp);
    cfg_last = AW'(last); m_last = last; loop_en = lp; m_loop = lp;
  endtask

  task automatic drv_reset();
    rst = 1'b1; m_reset(); #1;
    check("async_reset_pat", int'(pat_sel), 7);
    check("async_reset_pause", int'(pause), 1);
    check("async_reset_busy", int'(busy), 0);
    step_clk(); rst = 1'b0; gap();
  endtask

  task automatic program_plan_table();
    drv_write(0, {6'd2, 1'b0, 3'd0});
    drv_write(1, {6'd1, 1'b1, 3'd3});
    drv_write(2, {6'd3, 1'b0, 3'd5});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; tick = 0; cfg_we = 0; cfg_addr = '0; cfg_data = '0; cfg_last = '0;
    loop_en = 0; start = 0; stop = 0; hold = 0; skip = 0;
    m_last = 0; m_loop = 0; m_ticks = '0; m_prev = RST_SNAP;
    m_reset();
    repeat (3) step_clk();
    check("reset_pat_sel", int'(pat_sel), 7);
    check("reset_speed_sel", int'(speed_sel), 0);
    check("reset_pause", int'(pause), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_step_idx", int'(step_idx), 0);
    check("reset_seq_done", int'(seq_done), 0);
    rst = 1'b0; mon_en = 1; step_clk();

    // Play once through three steps.
    program_plan_table();
    set_cfg(2, 0);
    drv_start();
    repeat (6) drv_tick();
    drain("drain_play_once");
    check("once_end_pat", int'(pat_sel), 5);
    check("once_end_busy", int'(busy), 0);
    check("once_end_pause", int'(pause), 1);

    // Loop for three full passes, then abort.
    set_cfg(2, 1);
    drv_start();
    repeat (18) drv_tick();
    drain("drain_loop");
    check("loop_busy", int'(busy), 1);
    check("loop_back_idx", int'(step_idx), 0);
    drv_stop(0);

    // Hold, skip, skip+stop.
    set_cfg(2, 0);
    drv_start();
    drv_tick();
    drv_hold_on(0);
    repeat (5) drv_tick();
    check("hold_idx", int'(step_idx), 0);
    check("hold_pause", int'(pause), 1);
    drv_hold_off();
    drv_tick();
    drain("drain_hold");
    check("after_hold_idx", int'(step_idx), 1);
    drv_skip();
    drain("drain_skip");
    check("after_skip_pat", int'(pat_sel), 5);
    drv_stop(1);
    drain("drain_skip_stop");

    // Reset mid-playback wipes the table.
    set_cfg(2, 0);
    drv_start();
    repeat (2) drv_tick();
    drv_reset();
    set_cfg(0, 0);
    drv_start();
    drv_tick();
    drain("drain_after_reset");

    // Rewrite the playing step and attempt an out-of-range write.
    drv_write(0, {6'd4, 1'b0, 3'd1});
    drv_write(1, {6'd1, 1'b1, 3'd2});
    set_cfg(1, 1);
    drv_start();
    drv_tick();
    drv_write(0, {6'd2, 1'b0, 3'd6});
    drv_write(NS, {6'd1, 1'b1, 3'd4});
    check("rewrite_pat_unchanged", int'(pat_sel), 1);
    repeat (4) drv_tick();
    drain("drain_rewrite_load");
    check("rewrite_pat_new", int'(pat_sel), 6);
    repeat (2) drv_tick();
    drv_stop(0);
    drain("drain_rewrite");

    // Randomized rounds.
    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < NS; a++) begin
        drv_write(a, {6'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7))});
      end
      set_cfg($urandom_range(0, 7), 1'($urandom_range(0, 1)));
      for (int k = 0; k < 40; k++) begin
        int sel;
        sel = $urandom_range(0, 99);
        if (!m_play) begin
          if (sel < 50) drv_start();
          else if (sel < 80) drv_tick();
          else drv_write($urandom_range(0, 7), EW'($urandom_range(0, 1023)));
        end else if (sel < 55) drv_tick();
        else if (sel < 65) drv_skip();
        else if (sel < 77) begin
          drv_hold_on(sel >= 72);
          for (int h = $urandom_range(0, 3); h > 0; h--) drv_tick();
          if ($urandom_range(0, 1) == 1) drv_skip();
          drv_hold_off();
        end
        else if (sel < 85) drv_write($urandom_range(0, 7), {6'($urandom_range(0, 4)), 4'($urandom_range(0, 15))});
        else if (sel < 89) drv_stop(0);
        else if (sel < 93) drv_stop(1);
        else drv_start();
      end
      drv_stop(0);
      drain("drain_random");
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
